// File: rtl/fg_waveform_meas.sv
// Waveform measurement: recovers rise/ON/fall/low durations, period and peak of a
// trapezoid/pulse sample stream. Optional slope capture enabled by FG_MEAS_SLOPE_EN.
module fg_waveform_meas #(
    parameter int WAVEFORM_BITWIDTH = 16,
    parameter int COUNTER_BITWIDTH  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clk_en_i,
    input  logic [WAVEFORM_BITWIDTH:0]   sample_i,
    output logic [COUNTER_BITWIDTH-1:0]  rise_cnt_o,
    output logic [COUNTER_BITWIDTH-1:0]  on_cnt_o,
    output logic [COUNTER_BITWIDTH-1:0]  fall_cnt_o,
    output logic [COUNTER_BITWIDTH-1:0]  low_cnt_o,
    output logic [COUNTER_BITWIDTH-1:0]  period_o,
    output logic [WAVEFORM_BITWIDTH:0]   amplitude_o,
    output logic                         valid_o,
    output logic [WAVEFORM_BITWIDTH:0]   rise_step_o,
    output logic [WAVEFORM_BITWIDTH:0]   fall_step_o
);
    localparam int SW = WAVEFORM_BITWIDTH + 1;
    localparam int CW = COUNTER_BITWIDTH;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_RISE = 3'd1,
        ST_ON   = 3'd2,
        ST_FALL = 3'd3,
        ST_LOW  = 3'd4
    } state_t;

    function automatic logic [CW-1:0] f_sat_inc(input logic [CW-1:0] x);
        if (x == {CW{1'b1}}) begin
            f_sat_inc = x;
        end else begin
            f_sat_inc = x + {{(CW-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_start;
    logic             w_publish;
    logic [SW-1:0]    r_prev;
    logic [CW-1:0]    r_rise, r_on, r_fall, r_low;
    logic [CW-1:0]    w_rise_nxt, w_on_nxt, w_fall_nxt, w_low_nxt;
    logic [SW-1:0]    r_peak, w_peak_nxt;
    logic [CW+1:0]    w_period_sum;
    logic [CW-1:0]    w_period_clamped;
    logic [CW-1:0]    r_rise_out, r_on_out, r_fall_out, r_low_out, r_period_out;
    logic [SW-1:0]    r_amp_out;
    logic             r_valid;

    logic w_s_zero, w_s_gt, w_s_eq, w_s_lt;
    assign w_s_zero = (sample_i == {SW{1'b0}});
    assign w_s_gt   = (sample_i > r_prev);
    assign w_s_eq   = (sample_i == r_prev);
    assign w_s_lt   = (sample_i < r_prev);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_SYNC;
        end else if (clk_en_i) begin
            r_state <= w_state_nxt;
        end
    end

    // A restart out of FALL or LOW publishes the finished period and starts a new one.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_publish   = 1'b0;
        if (clk_en_i) begin
            case (r_state)
                ST_SYNC: begin
                    if ((r_prev == {SW{1'b0}}) && !w_s_zero) begin
                        w_state_nxt = ST_RISE;
                        w_start     = 1'b1;
                    end else begin
                        w_state_nxt = ST_SYNC;
                    end
                end
                ST_RISE: begin
                    if (w_s_zero)      w_state_nxt = ST_LOW;
                    else if (w_s_gt)   w_state_nxt = ST_RISE;
                    else if (w_s_eq)   w_state_nxt = ST_ON;
                    else               w_state_nxt = ST_FALL;
                end
                ST_ON: begin
                    if (w_s_zero)      w_state_nxt = ST_LOW;
                    else if (w_s_eq)   w_state_nxt = ST_ON;
                    else if (w_s_lt)   w_state_nxt = ST_FALL;
                    else               w_state_nxt = ST_SYNC;
                end
                ST_FALL: begin
                    if (w_s_zero) begin
                        w_state_nxt = ST_LOW;
                    end else if (w_s_lt) begin
                        w_state_nxt = ST_FALL;
                    end else begin
                        w_state_nxt = ST_RISE;
                        w_start     = 1'b1;
                        w_publish   = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (w_s_zero) begin
                        w_state_nxt = ST_LOW;
                    end else begin
                        w_state_nxt = ST_RISE;
                        w_start     = 1'b1;
                        w_publish   = 1'b1;
                    end
                end
                default: w_state_nxt = ST_SYNC;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Staying in a phase extends its counter; entering one starts it at 1.
    always_comb begin
        w_rise_nxt = r_rise;
        w_on_nxt   = r_on;
        w_fall_nxt = r_fall;
        w_low_nxt  = r_low;
        w_peak_nxt = r_peak;
        if (w_start) begin
            w_rise_nxt = {{(CW-1){1'b0}}, 1'b1};
            w_on_nxt   = {CW{1'b0}};
            w_fall_nxt = {CW{1'b0}};
            w_low_nxt  = {CW{1'b0}};
            w_peak_nxt = sample_i;
        end else if (clk_en_i) begin
            case (w_state_nxt)
                ST_RISE: begin
                    w_rise_nxt = f_sat_inc(r_rise);
                    w_peak_nxt = sample_i;
                end
                ST_ON:   w_on_nxt   = (r_state == ST_ON)   ? f_sat_inc(r_on)   : {{(CW-1){1'b0}}, 1'b1};
                ST_FALL: w_fall_nxt = (r_state == ST_FALL) ? f_sat_inc(r_fall) : {{(CW-1){1'b0}}, 1'b1};
                ST_LOW:  w_low_nxt  = (r_state == ST_LOW)  ? f_sat_inc(r_low)  : {{(CW-1){1'b0}}, 1'b1};
                default: w_peak_nxt = r_peak;
            endcase
        end else begin
            w_peak_nxt = r_peak;
        end
    end

    assign w_period_sum = {2'b00, r_rise} + {2'b00, r_on} + {2'b00, r_fall} + {2'b00, r_low};
    assign w_period_clamped = (|w_period_sum[CW+1:CW]) ? {CW{1'b1}} : w_period_sum[CW-1:0];

    // Counters, previous sample and published result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prev       <= {SW{1'b0}};
            r_rise       <= {CW{1'b0}};
            r_on         <= {CW{1'b0}};
            r_fall       <= {CW{1'b0}};
            r_low        <= {CW{1'b0}};
            r_peak       <= {SW{1'b0}};
            r_rise_out   <= {CW{1'b0}};
            r_on_out     <= {CW{1'b0}};
            r_fall_out   <= {CW{1'b0}};
            r_low_out    <= {CW{1'b0}};
            r_period_out <= {CW{1'b0}};
            r_amp_out    <= {SW{1'b0}};
            r_valid      <= 1'b0;
        end else begin
            r_valid <= w_publish;
            if (clk_en_i) begin
                r_prev <= sample_i;
                r_rise <= w_rise_nxt;
                r_on   <= w_on_nxt;
                r_fall <= w_fall_nxt;
                r_low  <= w_low_nxt;
                r_peak <= w_peak_nxt;
            end
            if (w_publish) begin
                r_rise_out   <= r_rise;
                r_on_out     <= r_on;
                r_fall_out   <= r_fall;
                r_low_out    <= r_low;
                r_period_out <= w_period_clamped;
                r_amp_out    <= r_peak;
            end
        end
    end

    assign rise_cnt_o  = r_rise_out;
    assign on_cnt_o    = r_on_out;
    assign fall_cnt_o  = r_fall_out;
    assign low_cnt_o   = r_low_out;
    assign period_o    = r_period_out;
    assign amplitude_o = r_amp_out;
    assign valid_o     = r_valid;

`ifdef FG_MEAS_SLOPE_EN
    logic [SW-1:0] r_rise_step, r_fall_step, w_rise_step_nxt, w_fall_step_nxt;
    logic [SW-1:0] r_rise_step_out, r_fall_step_out;

    // Fall step is captured on any entry into FALL, including straight from RISE.
    always_comb begin
        w_rise_step_nxt = r_rise_step;
        w_fall_step_nxt = r_fall_step;
        if (w_start) begin
            w_rise_step_nxt = sample_i - r_prev;
            w_fall_step_nxt = {SW{1'b0}};
        end else if (clk_en_i && (w_state_nxt == ST_FALL) && (r_state != ST_FALL)) begin
            w_fall_step_nxt = r_prev - sample_i;
        end else begin
            w_fall_step_nxt = r_fall_step;
        end
    end

    // Step capture and publication.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rise_step     <= {SW{1'b0}};
            r_fall_step     <= {SW{1'b0}};
            r_rise_step_out <= {SW{1'b0}};
            r_fall_step_out <= {SW{1'b0}};
        end else begin
            if (clk_en_i) begin
                r_rise_step <= w_rise_step_nxt;
                r_fall_step <= w_fall_step_nxt;
            end
            if (w_publish) begin
                r_rise_step_out <= r_rise_step;
                r_fall_step_out <= r_fall_step;
            end
        end
    end

    assign rise_step_o = r_rise_step_out;
    assign fall_step_o = r_fall_step_out;
`else
    assign rise_step_o = {SW{1'b0}};
    assign fall_step_o = {SW{1'b0}};
`endif

endmodule

// File: tb/tb_fg_waveform_meas.sv
// Self-checking bench for fg_waveform_meas: directed streams plus randomised trapezoids,
// compared against a per-sample phase model with unbounded counts saturated at read-out.
module tb_fg_waveform_meas;
    localparam int WB   = 8;
    localparam int CW   = 5;
    localparam int SW   = WB + 1;
    localparam int CMAX = (1 << CW) - 1;
`ifdef FG_MEAS_SLOPE_EN
    localparam bit SLOPE = 1'b1;
`else
    localparam bit SLOPE = 1'b0;
`endif

    localparam int P_SYNC = 0, P_RISE = 1, P_ON = 2, P_FALL = 3, P_LOW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          clk_en_i = 1'b0;
    logic [SW-1:0] sample_i = '0;
    logic [CW-1:0] rise_cnt_o, on_cnt_o, fall_cnt_o, low_cnt_o, period_o;
    logic [SW-1:0] amplitude_o, rise_step_o, fall_step_o;
    logic          valid_o;

    fg_waveform_meas #(.WAVEFORM_BITWIDTH(WB), .COUNTER_BITWIDTH(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i), .sample_i(sample_i),
        .rise_cnt_o(rise_cnt_o), .on_cnt_o(on_cnt_o), .fall_cnt_o(fall_cnt_o),
        .low_cnt_o(low_cnt_o), .period_o(period_o), .amplitude_o(amplitude_o),
        .valid_o(valid_o), .rise_step_o(rise_step_o), .fall_step_o(fall_step_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference model state: phase, previous sample, plain integer durations.
    int m_phase, m_prev, m_rise, m_on, m_fall, m_low, m_peak, m_rstep, m_fstep;
    int e_rise, e_on, e_fall, e_low, e_period, e_amp, e_rstep, e_fstep;
    bit e_valid;

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic model_reset();
        m_phase = P_SYNC; m_prev = 0;
        m_rise = 0; m_on = 0; m_fall = 0; m_low = 0; m_peak = 0; m_rstep = 0; m_fstep = 0;
        e_rise = 0; e_on = 0; e_fall = 0; e_low = 0; e_period = 0; e_amp = 0;
        e_rstep = 0; e_fstep = 0; e_valid = 1'b0;
    endtask

    task automatic model_publish();
        e_rise = sat(m_rise); e_on = sat(m_on); e_fall = sat(m_fall); e_low = sat(m_low);
        e_period = sat(m_rise + m_on + m_fall + m_low);
        e_amp = m_peak;
        e_rstep = SLOPE ? m_rstep : 0;
        e_fstep = SLOPE ? m_fstep : 0;
        e_valid = 1'b1;
    endtask

    task automatic model_start(input int s);
        m_phase = P_RISE; m_rise = 1; m_on = 0; m_fall = 0; m_low = 0;
        m_peak = s; m_rstep = s - m_prev; m_fstep = 0;
    endtask

    task automatic model_sample(input int s);
        e_valid = 1'b0;
        case (m_phase)
            P_SYNC: if (m_prev == 0 && s > 0) model_start(s);
            P_RISE: begin
                if (s == 0)           begin m_phase = P_LOW; m_low = 1; end
                else if (s > m_prev)  begin m_rise++; m_peak = s; end
                else if (s == m_prev) begin m_phase = P_ON; m_on = 1; end
                else begin m_phase = P_FALL; m_fall = 1; m_fstep = m_prev - s; end
            end
            P_ON: begin
                if (s == 0)           begin m_phase = P_LOW; m_low = 1; end
                else if (s == m_prev) m_on++;
                else if (s < m_prev)  begin m_phase = P_FALL; m_fall = 1; m_fstep = m_prev - s; end
                else                  m_phase = P_SYNC;
            end
            P_FALL: begin
                if (s == 0)          begin m_phase = P_LOW; m_low = 1; end
                else if (s < m_prev) m_fall++;
                else begin model_publish(); model_start(s); end
            end
            default: begin
                if (s == 0) m_low++;
                else begin model_publish(); model_start(s); end
            end
        endcase
        m_prev = s;
    endtask

    task automatic compare_all();
        check("valid", valid_o, e_valid);
        check("rise", rise_cnt_o, e_rise);
        check("on", on_cnt_o, e_on);
        check("fall", fall_cnt_o, e_fall);
        check("low", low_cnt_o, e_low);
        check("period", period_o, e_period);
        check("amplitude", amplitude_o, e_amp);
        check("rise_step", rise_step_o, e_rstep);
        check("fall_step", fall_step_o, e_fstep);
    endtask

    // One clock: drive at +1 after an edge, evaluate at +1 after the next edge.
    task automatic step(input bit en, input int s);
        logic [31:0] r;
        r = $urandom;
        clk_en_i = en;
        sample_i = en ? s[SW-1:0] : r[SW-1:0];
        @(posedge clk_i);
        #1;
        if (en) model_sample(s);
        else e_valid = 1'b0;
        compare_all();
    endtask

    task automatic feed(input int q[$], input bit gate);
        foreach (q[i]) begin
            if (gate) step(1'b0, 0);
            step(1'b1, q[i]);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #2;
        model_reset();
        compare_all();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic expect_last(input string t, input int r, input int o, input int f,
                               input int l, input int p, input int a, input int rs, input int fs);
        check({t, "_rise"}, rise_cnt_o, r);
        check({t, "_on"}, on_cnt_o, o);
        check({t, "_fall"}, fall_cnt_o, f);
        check({t, "_low"}, low_cnt_o, l);
        check({t, "_period"}, period_o, p);
        check({t, "_amp"}, amplitude_o, a);
        check({t, "_rstep"}, rise_step_o, SLOPE ? rs : 0);
        check({t, "_fstep"}, fall_step_o, SLOPE ? fs : 0);
    endtask

    int q[$];
    int kr, nr, top, kf, v, non, nlow;
    logic [31:0] rnd;

    initial begin
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        do_reset();

        q = '{0, 0, 4, 8, 12, 12, 12, 8, 4, 0, 0, 0, 4};
        feed(q, 1'b0);
        expect_last("t1", 3, 2, 2, 3, 10, 12, 4, 4);

        do_reset();
        feed(q, 1'b1);
        expect_last("t2", 3, 2, 2, 3, 10, 12, 4, 4);

        do_reset();
        q = '{0, 5, 10, 5, 0, 5};
        feed(q, 1'b0);
        expect_last("t3", 2, 0, 1, 1, 4, 10, 5, 5);

        do_reset();
        q = '{0, 3, 6, 6, 3, 6};
        feed(q, 1'b0);
        expect_last("t4", 2, 1, 1, 0, 4, 6, 3, 3);

        do_reset();
        q = '{0, 5, 5, 7, 0, 2, 0, 2};
        feed(q, 1'b0);
        expect_last("t5", 1, 0, 0, 1, 2, 2, 2, 0);

        do_reset();
        q = '{0, 3};
        for (int i = 0; i < 40; i++) q.push_back(0);
        q.push_back(3);
        feed(q, 1'b0);
        expect_last("t6", 1, 0, 0, 31, 31, 3, 3, 0);

        q = '{0, 2, 4};
        feed(q, 1'b0);
        do_reset();
        q = '{6, 8, 0, 5};
        feed(q, 1'b0);
        expect_last("t6r", 2, 0, 0, 1, 3, 8, 6, 0);

        // Randomised trapezoids with occasional noise, gating and mid-stream reset.
        for (int p = 0; p < 60; p++) begin
            q = {};
            rnd = $urandom;
            if (rnd[2:0] == 3'd0) begin
                for (int i = 0; i < 8; i++) q.push_back(int'($urandom_range(0, 3)) * 4);
            end else begin
                kr = $urandom_range(1, 20); nr = $urandom_range(1, 6); top = kr * nr;
                for (int i = 1; i <= nr; i++) q.push_back(kr * i);
                non = $urandom_range(0, 20);
                for (int i = 0; i < non; i++) q.push_back(top);
                kf = $urandom_range(1, 25);
                v = top - kf;
                while (v > 0) begin q.push_back(v); v -= kf; end
                nlow = $urandom_range(0, 40);
                for (int i = 0; i < nlow; i++) q.push_back(0);
            end
            foreach (q[i]) begin
                rnd = $urandom;
                if (rnd[1:0] == 2'd0) step(1'b0, 0);
                step(1'b1, q[i]);
            end
            rnd = $urandom;
            if (rnd[5:0] == 6'd0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
